// File: rtl/ila_pattern_gen_pkg.sv
// Shared definitions for the ILA pattern generator: FSM encoding and
// the ceiling-division helper used to derive the number of beats per sample.
package ila_pattern_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_PLAY  = 2'd2
  } state_t;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ila_pattern_gen_ram.sv
// Simple dual-port sample buffer: one write port, one read port with a
// registered read, both on the same clock and frozen by the clock enable.
module ila_pattern_gen_ram #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (we_i) mem[waddr_i] <= wdata_i;
      if (re_i) rdata_o <= mem[raddr_i];
    end
  end

endmodule

// File: rtl/ila_pattern_gen.sv
// Pattern generator: assembles DMA beats into samples in a buffer and replays
// them on pattern_o, once or circularly, optionally after an external trigger.
module ila_pattern_gen
  import ila_pattern_gen_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SIGNAL_W = 64,
  parameter int BUFFER_W = 8
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                cke_i,
  input  logic                rst_soft_i,
  input  logic [DATA_W-1:0]   dma_tdata_i,
  input  logic                dma_tvalid_i,
  output logic                dma_tready_o,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic                stop_i,
  input  logic                circular_i,
  input  logic                trigger_en_i,
  input  logic                trigger_i,
  output logic [SIGNAL_W-1:0] pattern_o,
  output logic                pattern_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [BUFFER_W:0]   loaded_o
);

  localparam int PARTS  = ceil_div(SIGNAL_W, DATA_W);
  localparam int PART_W = (PARTS > 1) ? $clog2(PARTS) : 1;
  localparam int ASM_W  = PARTS * DATA_W;
  localparam logic [PART_W-1:0] LAST_PART = PART_W'(PARTS - 1);
  localparam logic [BUFFER_W:0] ONE       = (BUFFER_W + 1)'(1);

  state_t                state_reg, state_next;
  logic [BUFFER_W:0]     rd_ptr_reg, rd_ptr_next;
  logic [BUFFER_W:0]     loaded_reg;
  logic [PART_W-1:0]     part_reg;
  logic [ASM_W-1:0]      asm_reg;
  logic [ASM_W-1:0]      asm_next;
  logic                  rd_valid_d1_reg, rd_last_d1_reg, last_d2_reg;
  logic                  valid_reg, done_reg;
  logic [SIGNAL_W-1:0]   pattern_reg;
  logic [SIGNAL_W-1:0]   ram_rdata;
  logic                  rd_en, rd_last;
  logic                  beat_acc, sample_wr, clear_now, stop_play;

  // Current beat dropped into its slot of the assembly word.
  for (genvar gi = 0; gi < PARTS; gi++) begin : g_asm
    assign asm_next[gi*DATA_W +: DATA_W] =
      (part_reg == PART_W'(gi)) ? dma_tdata_i : asm_reg[gi*DATA_W +: DATA_W];
  end

  assign dma_tready_o = (state_reg == ST_IDLE) && !loaded_reg[BUFFER_W];
  assign beat_acc     = dma_tvalid_i && dma_tready_o;
  assign clear_now    = clear_i && (state_reg == ST_IDLE);
  assign sample_wr    = beat_acc && (part_reg == LAST_PART) && !clear_now;
  assign stop_play    = stop_i && (state_reg == ST_PLAY);

  always_comb begin
    state_next  = state_reg;
    rd_ptr_next = rd_ptr_reg;
    rd_en       = 1'b0;
    rd_last     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start_i && !stop_i && (loaded_reg != '0)) begin
          state_next  = trigger_en_i ? ST_ARMED : ST_PLAY;
          rd_ptr_next = '0;
        end
      end
      ST_ARMED: begin
        if (stop_i) begin
          state_next = ST_IDLE;
        end else if (trigger_i) begin
          state_next  = ST_PLAY;
          rd_ptr_next = '0;
        end
      end
      ST_PLAY: begin
        if (stop_i) begin
          state_next = ST_IDLE;
        end else if (rd_ptr_reg == loaded_reg) begin
          // Drain cycle after the final read of a one-shot playback.
          state_next = ST_IDLE;
        end else begin
          rd_en = 1'b1;
          if (rd_ptr_reg == loaded_reg - ONE) begin
            if (circular_i) begin
              rd_ptr_next = '0;
            end else begin
              rd_ptr_next = loaded_reg;
              rd_last     = 1'b1;
            end
          end else begin
            rd_ptr_next = rd_ptr_reg + ONE;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_reg       <= ST_IDLE;
      rd_ptr_reg      <= '0;
      loaded_reg      <= '0;
      part_reg        <= '0;
      asm_reg         <= '0;
      rd_valid_d1_reg <= 1'b0;
      rd_last_d1_reg  <= 1'b0;
      last_d2_reg     <= 1'b0;
      valid_reg       <= 1'b0;
      done_reg        <= 1'b0;
      pattern_reg     <= '0;
    end else if (cke_i) begin
      if (rst_soft_i) begin
        state_reg       <= ST_IDLE;
        rd_ptr_reg      <= '0;
        loaded_reg      <= '0;
        part_reg        <= '0;
        asm_reg         <= '0;
        rd_valid_d1_reg <= 1'b0;
        rd_last_d1_reg  <= 1'b0;
        last_d2_reg     <= 1'b0;
        valid_reg       <= 1'b0;
        done_reg        <= 1'b0;
        pattern_reg     <= '0;
      end else begin
        state_reg  <= state_next;
        rd_ptr_reg <= rd_ptr_next;

        if (clear_now) begin
          loaded_reg <= '0;
          part_reg   <= '0;
        end else if (beat_acc) begin
          if (part_reg == LAST_PART) begin
            part_reg   <= '0;
            loaded_reg <= loaded_reg + ONE;
          end else begin
            part_reg <= part_reg + PART_W'(1);
            asm_reg  <= asm_next;
          end
        end

        // Read pipeline: RAM stage, then output stage; stop kills the end marker.
        rd_valid_d1_reg <= rd_en;
        rd_last_d1_reg  <= rd_last;
        last_d2_reg     <= rd_last_d1_reg && !stop_play;
        done_reg        <= last_d2_reg && !stop_play;
        valid_reg       <= rd_valid_d1_reg;
        if (rd_valid_d1_reg) pattern_reg <= ram_rdata;
      end
    end
  end

  ila_pattern_gen_ram #(
    .DATA_W (SIGNAL_W),
    .ADDR_W (BUFFER_W)
  ) u_ram (
    .clk_i   (clk_i),
    .cke_i   (cke_i),
    .we_i    (sample_wr),
    .waddr_i (loaded_reg[BUFFER_W-1:0]),
    .wdata_i (asm_next[SIGNAL_W-1:0]),
    .re_i    (rd_en),
    .raddr_i (rd_ptr_reg[BUFFER_W-1:0]),
    .rdata_o (ram_rdata)
  );

  assign pattern_o       = pattern_reg;
  assign pattern_valid_o = valid_reg;
  assign busy_o          = (state_reg == ST_ARMED) || (state_reg == ST_PLAY);
  assign done_o          = done_reg;
  assign loaded_o        = loaded_reg;

endmodule

// File: tb/tb_ila_pattern_gen.sv
// Directed bench for ila_pattern_gen: table-driven stream loading plus
// hand-written playback, trigger, circular, clear and reset sequences.
module tb_ila_pattern_gen;

  localparam int DATA_W   = 32;
  localparam int SIGNAL_W = 64;
  localparam int BUFFER_W = 2;

  logic                clk_i = 1'b0;
  logic                arst_n_i, cke_i, rst_soft_i;
  logic [DATA_W-1:0]   dma_tdata_i;
  logic                dma_tvalid_i, dma_tready_o;
  logic                clear_i, start_i, stop_i, circular_i, trigger_en_i, trigger_i;
  logic [SIGNAL_W-1:0] pattern_o;
  logic                pattern_valid_o, busy_o, done_o;
  logic [BUFFER_W:0]   loaded_o;

  always #5 clk_i = ~clk_i;

  ila_pattern_gen #(.DATA_W(DATA_W), .SIGNAL_W(SIGNAL_W), .BUFFER_W(BUFFER_W)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i), .cke_i(cke_i), .rst_soft_i(rst_soft_i),
    .dma_tdata_i(dma_tdata_i), .dma_tvalid_i(dma_tvalid_i), .dma_tready_o(dma_tready_o),
    .clear_i(clear_i), .start_i(start_i), .stop_i(stop_i), .circular_i(circular_i),
    .trigger_en_i(trigger_en_i), .trigger_i(trigger_i), .pattern_o(pattern_o),
    .pattern_valid_o(pattern_valid_o), .busy_o(busy_o), .done_o(done_o), .loaded_o(loaded_o)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              exp_ready;
    logic [BUFFER_W:0] exp_loaded;
  } beat_vec_t;

  beat_vec_t     vecs [0:15];
  logic [63:0]   exp_s [0:7];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_beat(input logic [DATA_W-1:0] d);
    dma_tdata_i  = d;
    dma_tvalid_i = 1'b1;
    tick();
    dma_tvalid_i = 1'b0;
    $display("beat 0x%0h loaded=%0d", d, loaded_o);
  endtask

  task automatic run_table(input int n);
    for (int i = 0; i < n; i++) begin
      dma_tdata_i  = vecs[i].data;
      dma_tvalid_i = 1'b1;
      #0;
      chk($sformatf("tready v%0d", i), dma_tready_o, vecs[i].exp_ready);
      tick();
      chk($sformatf("loaded v%0d", i), loaded_o, vecs[i].exp_loaded);
      $display("vec %0d data=0x%0h tready=%0b loaded=%0d", i, vecs[i].data, vecs[i].exp_ready, loaded_o);
    end
    dma_tvalid_i = 1'b0;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Called right after the edge that moves the FSM into PLAY.
  task automatic check_play(input int n);
    int dones = 0;
    for (int c = 1; c <= n + 3; c++) begin
      tick();
      chk($sformatf("valid c%0d", c), pattern_valid_o, (c >= 2 && c <= n + 1));
      if (c >= 2 && c <= n + 1) chk($sformatf("pattern c%0d", c), pattern_o, exp_s[c-2]);
      chk($sformatf("busy c%0d", c), busy_o, (c <= n));
      chk($sformatf("done c%0d", c), done_o, (c == n + 2));
      if (done_o) dones++;
      $display("play c%0d valid=%0b pattern=0x%0h busy=%0b done=%0b", c, pattern_valid_o, pattern_o, busy_o, done_o);
    end
    chk("done pulses", 64'(dones), 64'd1);
    chk("pattern hold", pattern_o, exp_s[n-1]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    arst_n_i = 1'b0; cke_i = 1'b1; rst_soft_i = 1'b0;
    dma_tdata_i = '0; dma_tvalid_i = 1'b0;
    clear_i = 1'b0; start_i = 1'b0; stop_i = 1'b0;
    circular_i = 1'b0; trigger_en_i = 1'b0; trigger_i = 1'b0;
    #22 arst_n_i = 1'b1;
    tick();

    // Reset state
    chk("rst tready", dma_tready_o, 1'b1);
    chk("rst pattern", pattern_o, 64'd0);
    chk("rst valid", pattern_valid_o, 1'b0);
    chk("rst busy", busy_o, 1'b0);
    chk("rst done", done_o, 1'b0);
    chk("rst loaded", loaded_o, 3'd0);

    // Start with empty buffer is ignored
    pulse_start();
    chk("empty start busy", busy_o, 1'b0);
    tick(); tick();
    chk("empty start valid", pattern_valid_o, 1'b0);

    // Load three samples, least-significant part first
    vecs[0] = '{32'h1, 1'b1, 3'd0};
    vecs[1] = '{32'hA, 1'b1, 3'd1};
    vecs[2] = '{32'h2, 1'b1, 3'd1};
    vecs[3] = '{32'hB, 1'b1, 3'd2};
    vecs[4] = '{32'h3, 1'b1, 3'd2};
    vecs[5] = '{32'hC, 1'b1, 3'd3};
    run_table(6);
    exp_s[0] = 64'h0000000A_00000001;
    exp_s[1] = 64'h0000000B_00000002;
    exp_s[2] = 64'h0000000C_00000003;
    pulse_start();
    chk("play busy c0", busy_o, 1'b1);
    chk("play tready c0", dma_tready_o, 1'b0);
    check_play(3);

    // Trigger-gated playback
    trigger_en_i = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("armed busy %0d", i), busy_o, 1'b1);
      chk($sformatf("armed valid %0d", i), pattern_valid_o, 1'b0);
    end
    trigger_i = 1'b1;
    tick();
    trigger_i = 1'b0;
    trigger_en_i = 1'b0;
    check_play(3);

    // Circular playback, then stop
    circular_i = 1'b1;
    pulse_start();
    for (int c = 1; c <= 7; c++) begin
      tick();
      chk($sformatf("circ busy c%0d", c), busy_o, 1'b1);
      chk($sformatf("circ valid c%0d", c), pattern_valid_o, (c >= 2));
      if (c >= 2) chk($sformatf("circ pattern c%0d", c), pattern_o, exp_s[(c-2)%3]);
      $display("circ c%0d valid=%0b pattern=0x%0h", c, pattern_valid_o, pattern_o);
    end
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    circular_i = 1'b0;
    chk("stop busy", busy_o, 1'b0);
    tick();
    chk("stop valid", pattern_valid_o, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stop done %0d", i), done_o, 1'b0);
      tick();
    end

    // start and stop together: stop wins
    start_i = 1'b1; stop_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("start+stop busy", busy_o, 1'b0);
    tick(); tick();
    chk("start+stop valid", pattern_valid_o, 1'b0);

    // clear discards a half-assembled sample
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    chk("clear loaded", loaded_o, 3'd0);
    send_beat(32'hDEAD_BEEF);
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    send_beat(32'h11);
    send_beat(32'h22);
    chk("clear reassemble loaded", loaded_o, 3'd1);
    exp_s[0] = 64'h00000022_00000011;
    pulse_start();
    check_play(1);

    // Full buffer: 10 beats offered, only 8 accepted
    clear_i = 1'b1; tick(); clear_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vecs[i].data       = 32'h10 + 32'(i);
      vecs[i].exp_ready  = (i < 8);
      vecs[i].exp_loaded = (i < 8) ? 3'((i + 1) / 2) : 3'd4;
    end
    run_table(10);
    for (int k = 0; k < 4; k++) exp_s[k] = {32'h10 + 32'(2*k + 1), 32'h10 + 32'(2*k)};
    pulse_start();
    check_play(4);

    // Asynchronous reset mid-playback
    pulse_start();
    tick(); tick(); tick();
    chk("pre-arst valid", pattern_valid_o, 1'b1);
    #1 arst_n_i = 1'b0;
    #1;
    chk("arst pattern", pattern_o, 64'd0);
    chk("arst valid", pattern_valid_o, 1'b0);
    chk("arst busy", busy_o, 1'b0);
    chk("arst done", done_o, 1'b0);
    chk("arst loaded", loaded_o, 3'd0);
    #1 arst_n_i = 1'b1;
    tick();
    chk("arst tready", dma_tready_o, 1'b1);

    // Soft reset mid-playback
    send_beat(32'h5);
    send_beat(32'h6);
    pulse_start();
    tick(); tick();
    chk("pre-soft valid", pattern_valid_o, 1'b1);
    chk("pre-soft pattern", pattern_o, 64'h00000006_00000005);
    rst_soft_i = 1'b1;
    tick();
    rst_soft_i = 1'b0;
    chk("soft pattern", pattern_o, 64'd0);
    chk("soft valid", pattern_valid_o, 1'b0);
    chk("soft busy", busy_o, 1'b0);
    chk("soft loaded", loaded_o, 3'd0);
    chk("soft tready", dma_tready_o, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("soft done %0d", i), done_o, 1'b0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ila_pattern_gen.md
# ila_pattern_gen

Pattern generator, the output-side counterpart of the ILA sample buffer. Receives sample words over a DMA stream sink (DATA_W-wide beats, tvalid/tready), reassembles them into SIGNAL_W-wide samples and stores them in an on-chip buffer. On command it replays the buffer onto a parallel output bus, once or circularly, optionally gated by an external trigger. Sits beside the ILA core in the peripheral; software loads the buffer via DMA and starts playback via control registers.

## Interface
- DATA_W, 32, stream beat width and register width
- SIGNAL_W, 64, width of one replayed sample
- BUFFER_W, 8, buffer address width; capacity 2^BUFFER_W samples
- clk_i  in  1  system clock; all logic single-clock
- arst_n_i  in  1  asynchronous reset, active-low
- cke_i  in  1  clock enable; low freezes all state
- rst_soft_i  in  1  synchronous soft reset, same effect as reset except buffer contents
- dma_tdata_i  in  DATA_W  sample data beat
- dma_tvalid_i  in  1  beat valid
- dma_tready_o  out  1  beat accepted when tvalid & tready
- clear_i  in  1  pulse: empty buffer (loaded_o := 0)
- start_i  in  1  pulse: begin playback
- stop_i  in  1  pulse: abort playback
- circular_i  in  1  wrap playback continuously
- trigger_en_i  in  1  wait for trigger_i before playing
- trigger_i  in  1  external trigger, level-sensitive
- pattern_o  out  SIGNAL_W  replayed sample
- pattern_valid_o  out  1  pattern_o holds a sample of the current playback
- busy_o  out  1  state is ARMED or PLAY
- done_o  out  1  one-cycle pulse at end of non-circular playback
- loaded_o  out  BUFFER_W+1  number of samples stored

## Operation
- PARTS = CEIL_DIV(SIGNAL_W, DATA_W). Sample assembled least-significant part first; bits of last part above SIGNAL_W discarded.
- Part counter 0..PARTS-1; on acceptance of part PARTS-1 the sample is written at address loaded_o[BUFFER_W-1:0] and loaded_o increments.
- dma_tready_o = 1 only in IDLE and loaded_o < 2^BUFFER_W. Full: tready 0, no overwrite.
- clear_i (IDLE only, ignored otherwise): loaded_o := 0, part counter := 0; a partially assembled sample is discarded.
- States IDLE, ARMED, PLAY:
  - IDLE: start_i & loaded_o>0 -> ARMED if trigger_en_i else PLAY; start_i with loaded_o==0 ignored.
  - ARMED: trigger_i==1 -> PLAY; stop_i -> IDLE.
  - PLAY: read pointer 0..loaded_o-1, one sample per enabled cycle. At last address: circular_i -> wrap to 0 with no gap; else -> IDLE and done_o pulse. stop_i -> IDLE, no done_o.
- stop_i and start_i same cycle: stop wins. stop_i in IDLE: no effect.
- circular_i, trigger_en_i sampled at each decision point (not latched).
- pattern_o holds last presented value after playback ends; pattern_valid_o drops.

## Timing
- Reset (async or soft): state IDLE, dma_tready_o 1 after reset deasserts, pattern_o 0, pattern_valid_o 0, busy_o 0, done_o 0, loaded_o 0, part counter 0. Buffer contents undefined after reset.
- Reset mid-playback: immediate return to IDLE, outputs to reset values; no done_o.
- Buffer read latency 1 cycle. start_i sampled at edge N (no trigger): sample 0 on pattern_o, pattern_valid_o=1 after edge N+2; sample k after edge N+2+k.
- ARMED: trigger_i sampled high at edge M -> sample 0 after edge M+2.
- Non-circular, L samples: pattern_valid_o high exactly L cycles; done_o high in the cycle after the last sample's valid cycle, concurrent with pattern_valid_o falling; busy_o falls one cycle earlier (when state leaves PLAY).
- stop_i at edge S: pattern_valid_o low after edge S+1.
- Stream: a beat is transferred in every cycle with tvalid & tready; full throughput 1 beat/cycle; loaded_o updates after the edge accepting the last part.

## Structure
- Shared header: state encoding constants, CEIL_DIV macro (existing iob_ila_lib.vh), PARTS derivation.
- One sub-module: iob_ram_2p (single clock, 1 write / 1 read port, registered read, SIGNAL_W x 2^BUFFER_W).
- Assembly register, counters, FSM in this module.

## Test plan
- Load: SIGNAL_W=64, DATA_W=32, beats 0x1,0xA,0x2,0xB,0x3,0xC -> loaded_o=3; playback gives 0x0000000A_00000001, 0x..0B_..02, 0x..0C_..03, done_o one pulse, pattern_valid_o high 3 cycles.
- Full: BUFFER_W=2, offer 10 beats continuously -> tready drops after beat 8, loaded_o=4, beats 9-10 not accepted.
- Trigger: trigger_en_i=1, start, trigger_i low 10 cycles -> busy_o=1, pattern_valid_o=0; trigger_i high -> sample 0 after 2 edges.
- Circular + stop: 3 samples, circular_i=1, observe 0,1,2,0,1,2 contiguous; stop_i -> pattern_valid_o low next cycle, no done_o.
- Boundaries: start with loaded_o=0 -> stays IDLE; start+stop same cycle -> stays IDLE; clear_i after 1 beat of 2 -> next 2 beats form sample 0.
- Reset: arst_n_i low mid-PLAY -> all outputs reset immediately; rst_soft_i same behaviour synchronously.
